// File: rtl/uart_rx_core.sv
// uart_rx_core: baud tick generator plus 8-N-1 UART receiver for the RS-232 pin
// Ports: I_clk/I_rst_n clock and async active-low reset; I_rx_start receive enable (checked in IDLE);
//   I_rs232_rxd serial line in; I_bps_tx_clk_en / O_bps_tx_clk transmit baud enable and tick;
//   O_para_data last good byte; O_rx_done one-cycle byte strobe; O_rs232_rxd line echo.
// Macro UART_RX_LOOPBACK_EN: echo the synchronized line on O_rs232_rxd, otherwise drive idle mark.
module uart_rx_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD = 115200
) (
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       I_rx_start,
  input  logic       I_rs232_rxd,
  input  logic       I_bps_tx_clk_en,
  output logic       O_bps_tx_clk,
  output logic [7:0] O_para_data,
  output logic       O_rx_done,
  output logic       O_rs232_rxd
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW = $clog2(DIV);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_nxt;
  logic rxd_s1, rxd_s2, rxd_s3;
  logic fall, tick;
  logic [CW-1:0] rx_cnt, tx_cnt;
  logic [3:0] bit_idx;
  logic [7:0] shift;
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) {rxd_s1, rxd_s2, rxd_s3} <= 3'b111;
    else {rxd_s1, rxd_s2, rxd_s3} <= {I_rs232_rxd, rxd_s1, rxd_s2};
  assign fall = rxd_s3 & ~rxd_s2;
  assign tick = (state == RECV) && (rx_cnt == CW'(HALF));
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = (I_rx_start && fall) ? RECV : IDLE;
    else state_nxt = (tick && ((bit_idx == 4'd0 && rxd_s2) || bit_idx == 4'd9)) ? IDLE : RECV;
  end
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      rx_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      O_para_data <= '0;
      O_rx_done <= 1'b0;
    end else begin
      O_rx_done <= 1'b0;
      if (state != RECV) begin
        rx_cnt <= '0;
        bit_idx <= '0;
      end else begin
        rx_cnt <= (rx_cnt == CW'(DIV - 1)) ? '0 : rx_cnt + 1'b1;
        if (tick) begin
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx >= 4'd1 && bit_idx <= 4'd8) shift <= {rxd_s2, shift[7:1]};
          if (bit_idx == 4'd9 && rxd_s2) begin
            O_para_data <= shift;
            O_rx_done <= 1'b1;
          end
        end
      end
    end
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) tx_cnt <= '0;
    else tx_cnt <= (!I_bps_tx_clk_en || tx_cnt == CW'(DIV - 1)) ? '0 : tx_cnt + 1'b1;
  assign O_bps_tx_clk = I_bps_tx_clk_en && (tx_cnt == CW'(DIV - 1));
`ifdef UART_RX_LOOPBACK_EN
  assign O_rs232_rxd = rxd_s2;
`else
  assign O_rs232_rxd = 1'b1;
`endif
endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed self-checking bench for uart_rx_core
module tb_uart_rx_core;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD = 921_600;
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int LAT = 4 + HALF + 9 * DIV;
  logic clk = 1'b0, rst_n = 1'b0, rx_start = 1'b0, rxd = 1'b1, tx_en = 1'b0;
  logic bps_tx_clk, rx_done, rs232_out;
  logic [7:0] para_data, last_data;
  int cyc = 0, done_n = 0, tick_n = 0, done_cyc = 0, start_cyc = 0;
  int pass_n = 0, total_n = 0;
  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_rx_start(rx_start), .I_rs232_rxd(rxd),
    .I_bps_tx_clk_en(tx_en), .O_bps_tx_clk(bps_tx_clk), .O_para_data(para_data),
    .O_rx_done(rx_done), .O_rs232_rxd(rs232_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rx_done) begin
      done_n++;
      done_cyc = cyc;
      last_data = para_data;
    end
    if (bps_tx_clk) tick_n++;
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = 1'b1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total_n++; if (para_data !== 8'h00) $display("FAIL rst_data: got %h exp 00", para_data); else pass_n++;
    total_n++; if (rx_done !== 1'b0) $display("FAIL rst_done: got %b exp 0", rx_done); else pass_n++;
    total_n++; if (bps_tx_clk !== 1'b0) $display("FAIL rst_bps: got %b exp 0", bps_tx_clk); else pass_n++;
    total_n++; if (rs232_out !== 1'b1) $display("FAIL rst_echo: got %b exp 1", rs232_out); else pass_n++;
    rst_n = 1'b1;
    repeat (10000) @(negedge clk);
    total_n++; if (done_n !== 0) $display("FAIL idle_done: got %0d strobes exp 0", done_n); else pass_n++;
    total_n++; if (tick_n !== 0) $display("FAIL idle_ticks: got %0d exp 0", tick_n); else pass_n++;
    total_n++; if (para_data !== 8'h00) $display("FAIL idle_data: got %h exp 00", para_data); else pass_n++;
  endtask
  task automatic test_basic;
    int d0;
    rx_start = 1'b1;
    d0 = done_n;
    send_byte(8'h55, 1'b1);
    total_n++; if (done_n !== d0 + 1) $display("FAIL b55_strobe: got %0d exp %0d", done_n - d0, 1); else pass_n++;
    total_n++; if (para_data !== 8'h55) $display("FAIL b55_data: got %h exp 55", para_data); else pass_n++;
    total_n++; if (last_data !== 8'h55) $display("FAIL b55_at_strobe: got %h exp 55", last_data); else pass_n++;
    total_n++; if (done_cyc - start_cyc !== LAT) $display("FAIL b55_latency: got %0d exp %0d", done_cyc - start_cyc, LAT); else pass_n++;
    send_byte(8'hA3, 1'b1);
    total_n++; if (done_n !== d0 + 2) $display("FAIL bA3_strobe: got %0d exp %0d", done_n - d0, 2); else pass_n++;
    total_n++; if (para_data !== 8'hA3) $display("FAIL bA3_data: got %h exp a3", para_data); else pass_n++;
    repeat (2 * DIV) @(negedge clk);
  endtask
  task automatic test_false_start;
    int d0;
    d0 = done_n;
    rxd = 1'b0;
    repeat (30) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    total_n++; if (done_n !== d0) $display("FAIL glitch_strobe: got %0d exp 0", done_n - d0); else pass_n++;
    total_n++; if (para_data !== 8'hA3) $display("FAIL glitch_data: got %h exp a3", para_data); else pass_n++;
    send_byte(8'h3C, 1'b1);
    total_n++; if (done_n !== d0 + 1) $display("FAIL b3C_strobe: got %0d exp 1", done_n - d0); else pass_n++;
    total_n++; if (para_data !== 8'h3C) $display("FAIL b3C_data: got %h exp 3c", para_data); else pass_n++;
  endtask
  task automatic test_framing;
    int d0;
    d0 = done_n;
    send_byte(8'h81, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    total_n++; if (done_n !== d0) $display("FAIL frm_strobe: got %0d exp 0", done_n - d0); else pass_n++;
    total_n++; if (para_data !== 8'h3C) $display("FAIL frm_hold: got %h exp 3c", para_data); else pass_n++;
    send_byte(8'h7E, 1'b1);
    total_n++; if (done_n !== d0 + 1) $display("FAIL b7E_strobe: got %0d exp 1", done_n - d0); else pass_n++;
    total_n++; if (para_data !== 8'h7E) $display("FAIL b7E_data: got %h exp 7e", para_data); else pass_n++;
  endtask
  task automatic test_rx_disabled;
    int d0;
    d0 = done_n;
    rx_start = 1'b0;
    send_byte(8'h12, 1'b1);
    repeat (DIV) @(negedge clk);
    total_n++; if (done_n !== d0) $display("FAIL dis_strobe: got %0d exp 0", done_n - d0); else pass_n++;
    total_n++; if (para_data !== 8'h7E) $display("FAIL dis_data: got %h exp 7e", para_data); else pass_n++;
    rx_start = 1'b1;
    send_byte(8'h12, 1'b1);
    total_n++; if (done_n !== d0 + 1) $display("FAIL b12_strobe: got %0d exp 1", done_n - d0); else pass_n++;
    total_n++; if (para_data !== 8'h12) $display("FAIL b12_data: got %h exp 12", para_data); else pass_n++;
  endtask
  task automatic test_reset_midframe;
    int d0;
    d0 = done_n;
    fork
      send_byte(8'hF5, 1'b1);
      begin
        repeat (5 * DIV + HALF) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_n++; if (para_data !== 8'h00) $display("FAIL mid_rst_data: got %h exp 00", para_data); else pass_n++;
        total_n++; if (rx_done !== 1'b0) $display("FAIL mid_rst_done: got %b exp 0", rx_done); else pass_n++;
        total_n++; if (rs232_out !== 1'b1) $display("FAIL mid_rst_echo: got %b exp 1", rs232_out); else pass_n++;
        rst_n = 1'b1;
      end
    join
    repeat (2 * DIV) @(negedge clk);
    total_n++; if (done_n !== d0) $display("FAIL mid_abort_strobe: got %0d exp 0", done_n - d0); else pass_n++;
    total_n++; if (para_data !== 8'h00) $display("FAIL mid_abort_data: got %h exp 00", para_data); else pass_n++;
    send_byte(8'hF0, 1'b1);
    total_n++; if (done_n !== d0 + 1) $display("FAIL bF0_strobe: got %0d exp 1", done_n - d0); else pass_n++;
    total_n++; if (para_data !== 8'hF0) $display("FAIL bF0_data: got %h exp f0", para_data); else pass_n++;
  endtask
  task automatic test_tx_tick;
    int t0;
    t0 = tick_n;
    tx_en = 1'b1;
    repeat (DIV - 2) @(negedge clk);
    total_n++; if (bps_tx_clk !== 1'b0) $display("FAIL tx_early: got %b exp 0", bps_tx_clk); else pass_n++;
    @(negedge clk);
    total_n++; if (bps_tx_clk !== 1'b1) $display("FAIL tx_first: got %b exp 1", bps_tx_clk); else pass_n++;
    repeat (4 * DIV + 1) @(negedge clk);
    total_n++; if (tick_n !== t0 + 5) $display("FAIL tx_count: got %0d exp 5", tick_n - t0); else pass_n++;
    tx_en = 1'b0;
    repeat (3 * DIV) @(negedge clk);
    total_n++; if (tick_n !== t0 + 5) $display("FAIL tx_stop: got %0d exp 5", tick_n - t0); else pass_n++;
  endtask
  task automatic test_loopback;
    int d0;
    logic lo;
`ifdef UART_RX_LOOPBACK_EN
    lo = 1'b0;
`else
    lo = 1'b1;
`endif
    d0 = done_n;
    rxd = 1'b0;
    @(negedge clk);
    total_n++; if (rs232_out !== 1'b1) $display("FAIL echo_d1: got %b exp 1", rs232_out); else pass_n++;
    @(negedge clk);
    total_n++; if (rs232_out !== lo) $display("FAIL echo_d2: got %b exp %b", rs232_out, lo); else pass_n++;
    rxd = 1'b1;
    @(negedge clk);
    total_n++; if (rs232_out !== lo) $display("FAIL echo_d3: got %b exp %b", rs232_out, lo); else pass_n++;
    @(negedge clk);
    total_n++; if (rs232_out !== 1'b1) $display("FAIL echo_d4: got %b exp 1", rs232_out); else pass_n++;
    repeat (2 * DIV) @(negedge clk);
    total_n++; if (done_n !== d0) $display("FAIL echo_strobe: got %0d exp 0", done_n - d0); else pass_n++;
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_false_start();
    test_framing();
    test_rx_disabled();
    test_reset_midframe();
    test_tx_tick();
    test_loopback();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
